// File: rtl/pixgen_pkg.sv
// Shared types and helpers for the synthetic pixel frame generator.
// Pattern encodings, FSM state enum and the 8-bit Fibonacci LFSR step.
package pixgen_pkg;

   localparam logic [1:0] PAT_COUNT = 2'd0;
   localparam logic [1:0] PAT_GRAD  = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_LFSR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Feedback taps on bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pixgen_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
// Ports: clk_in, rst (async high), load/load_val, adv, state out.
module pixgen_lfsr8
   import pixgen_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       adv,
   output logic [7:0] state
);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)
         state <= 8'h01;
      else if (load)
         state <= load_val;
      else if (adv)
         state <= lfsr_next(state);
   end

endmodule

// File: rtl/pixel_frame_gen.sv
// Synthetic raster pixel source with four test patterns and markers.
// Ports: start/cont/stop control, pattern/seed, valid/ready stream out,
// sof/eol/eof markers, busy and a completed-frame counter.
module pixel_frame_gen
   import pixgen_pkg::*;
#(
   parameter int IMG_W     = 8,
   parameter int IMG_H     = 8,
   parameter int LINE_GAP  = 2,
   parameter int GRAD_STEP = 16
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        start,
   input  logic        cont,
   input  logic        stop,
   input  logic [1:0]  pattern,
   input  logic [7:0]  seed,
   output logic [7:0]  pixel_out,
   output logic        valid_out,
   input  logic        ready_out,
   output logic        sof,
   output logic        eol,
   output logic        eof,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int GW = $clog2(LINE_GAP + 2);
   // With no gap configured a line end goes straight back to RUN
   localparam state_t AFTER_LINE = (LINE_GAP > 0) ? GAP : RUN;

   state_t         state_q, state_d;
   logic [XW-1:0]  x_q;
   logic [YW-1:0]  y_q;
   logic [GW-1:0]  gap_q;
   logic [1:0]     pat_q;
   logic [7:0]     seed_q;
   logic [7:0]     seed_fix;
   logic [7:0]     lfsr_s;
   logic [7:0]     pix;
   logic           xfer;
   logic           last_x;
   logic           last_y;
   logic           start_ok;
   logic           frame_done;

   assign valid_out = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign xfer      = valid_out && ready_out;
   assign last_x    = (x_q == XW'(IMG_W - 1));
   assign last_y    = (y_q == YW'(IMG_H - 1));
   assign seed_fix  = (seed == 8'h00) ? 8'h01 : seed;

   assign sof = valid_out && (x_q == '0) && (y_q == '0);
   assign eol = valid_out && last_x;
   assign eof = valid_out && last_x && last_y;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start_ok   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (xfer && last_x) begin
               if (last_y) begin
                  frame_done = 1'b1;
                  if (cont && !stop)
                     state_d = AFTER_LINE;
                  else
                     state_d = IDLE;
               end else begin
                  state_d = AFTER_LINE;
               end
            end
         end
         GAP: begin
            if (gap_q == '0)
               state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         x_q       <= '0;
         y_q       <= '0;
         gap_q     <= '0;
         pat_q     <= PAT_COUNT;
         seed_q    <= 8'h01;
         frame_cnt <= '0;
      end else begin
         if (start_ok) begin
            pat_q  <= pattern;
            seed_q <= seed_fix;
         end
         if (xfer) begin
            if (last_x) begin
               x_q <= '0;
               y_q <= last_y ? '0 : y_q + YW'(1);
            end else begin
               x_q <= x_q + XW'(1);
            end
         end
         if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
         // Gap counter counts down LINE_GAP-1..0, independent of ready
         if (state_q == RUN && state_d == GAP)
            gap_q <= GW'(LINE_GAP - 1);
         else if (state_q == GAP && gap_q != '0)
            gap_q <= gap_q - GW'(1);
      end
   end

   pixgen_lfsr8 u_lfsr (
      .clk_in   (clk_in),
      .rst      (rst),
      .load     (start_ok || frame_done),
      .load_val (start_ok ? seed_fix : seed_q),
      .adv      (xfer && !frame_done),
      .state    (lfsr_s)
   );

   always_comb begin
      pix = 8'h00;
      unique case (pat_q)
         PAT_COUNT: pix = 8'(y_q) * 8'(IMG_W) + 8'(x_q);
         PAT_GRAD:  pix = 8'(x_q) * 8'(GRAD_STEP);
         PAT_CHECK: pix = {8{x_q[0] ^ y_q[0]}};
         PAT_LFSR:  pix = lfsr_s;
         default:   pix = 8'h00;
      endcase
   end

   assign pixel_out = valid_out ? pix : 8'h00;

endmodule

// File: tb/tb_pixel_frame_gen.sv
// Directed self-checking bench for pixel_frame_gen.
// 4x3 frames, LINE_GAP=2, GRAD_STEP=16.
module tb_pixel_frame_gen;

   logic        clk_in = 1'b0;
   logic        rst;
   logic        start;
   logic        cont;
   logic        stop;
   logic [1:0]  pattern;
   logic [7:0]  seed;
   logic [7:0]  pixel_out;
   logic        valid_out;
   logic        ready_out;
   logic        sof;
   logic        eol;
   logic        eof;
   logic        busy;
   logic [15:0] frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] q_pix[$];
   logic [2:0] q_flg[$];
   int         q_cyc[$];

   pixel_frame_gen #(
      .IMG_W     (4),
      .IMG_H     (3),
      .LINE_GAP  (2),
      .GRAD_STEP (16)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .cont      (cont),
      .stop      (stop),
      .pattern   (pattern),
      .seed      (seed),
      .pixel_out (pixel_out),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .sof       (sof),
      .eol       (eol),
      .eof       (eof),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk_in = ~clk_in;

   // Record every accepted pixel with its markers and cycle index
   always @(negedge clk_in) begin
      cyc++;
      if (valid_out && ready_out) begin
         q_pix.push_back(pixel_out);
         q_flg.push_back({sof, eol, eof});
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      for (int k = 0; k < max && busy; k++)
         tick();
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_q(input int n, input int max);
      for (int k = 0; k < max && q_pix.size() < n; k++)
         tick();
      check("q_timeout", {31'd0, q_pix.size() >= n}, 32'd1);
   endtask

   task automatic clear_q();
      q_pix.delete();
      q_flg.delete();
      q_cyc.delete();
   endtask

   // {sof, eol, eof} expected for each pixel of a 4x3 frame
   logic [2:0] exp_flg[12] = '{3'b100, 3'b000, 3'b000, 3'b010,
                               3'b000, 3'b000, 3'b000, 3'b010,
                               3'b000, 3'b000, 3'b000, 3'b011};
   logic [7:0] exp_grad[12] = '{8'h00, 8'h10, 8'h20, 8'h30,
                                8'h00, 8'h10, 8'h20, 8'h30,
                                8'h00, 8'h10, 8'h20, 8'h30};
   logic [7:0] exp_chk[12] = '{8'h00, 8'hFF, 8'h00, 8'hFF,
                               8'hFF, 8'h00, 8'hFF, 8'h00,
                               8'h00, 8'hFF, 8'h00, 8'hFF};
   logic [7:0] exp_lfsr[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      cont      = 1'b0;
      stop      = 1'b0;
      pattern   = 2'd0;
      seed      = 8'h00;
      ready_out = 1'b1;
      tick();
      tick();
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
      check("rst_pix", {24'd0, pixel_out}, 32'd0);
      check("rst_mark", {29'd0, sof, eol, eof}, 32'd0);
      rst = 1'b0;
      tick();

      // Counter pattern, single frame
      clear_q();
      pulse_start();
      check("lat_valid", {31'd0, valid_out}, 32'd1);
      check("lat_sof", {31'd0, sof}, 32'd1);
      wait_idle(100);
      check("cnt_len", q_pix.size(), 32'd12);
      for (int i = 0; i < 12 && i < q_pix.size(); i++) begin
         check($sformatf("cnt_pix%0d", i), {24'd0, q_pix[i]}, i);
         check($sformatf("cnt_flg%0d", i), {29'd0, q_flg[i]},
               {29'd0, exp_flg[i]});
      end
      if (q_cyc.size() >= 12) begin
         check("gap_x0", q_cyc[1] - q_cyc[0] - 1, 32'd0);
         check("gap_l0", q_cyc[4] - q_cyc[3] - 1, 32'd2);
         check("gap_l1", q_cyc[8] - q_cyc[7] - 1, 32'd2);
      end
      check("cnt_fcnt", {16'd0, frame_cnt}, 32'd1);
      check("cnt_valid_end", {31'd0, valid_out}, 32'd0);

      // Backpressure on pixel 5
      clear_q();
      pulse_start();
      for (int k = 0; k < 50 && !(valid_out && pixel_out == 8'd5); k++)
         tick();
      check("bp_reach", {24'd0, pixel_out}, 32'd5);
      ready_out = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_in);
         check($sformatf("bp_hold_pix%0d", k), {24'd0, pixel_out}, 32'd5);
         check($sformatf("bp_hold_v%0d", k), {31'd0, valid_out}, 32'd1);
         tick();
      end
      ready_out = 1'b1;
      wait_idle(100);
      check("bp_len", q_pix.size(), 32'd12);
      for (int i = 0; i < 12 && i < q_pix.size(); i++)
         check($sformatf("bp_pix%0d", i), {24'd0, q_pix[i]}, i);
      check("bp_fcnt", {16'd0, frame_cnt}, 32'd2);

      // Gradient; pattern change mid-frame must be ignored
      clear_q();
      pattern = 2'd1;
      pulse_start();
      pattern = 2'd0;
      wait_idle(100);
      check("grad_len", q_pix.size(), 32'd12);
      for (int i = 0; i < 12 && i < q_pix.size(); i++)
         check($sformatf("grad_pix%0d", i), {24'd0, q_pix[i]},
               {24'd0, exp_grad[i]});

      // Checkerboard
      clear_q();
      pattern = 2'd2;
      pulse_start();
      wait_idle(100);
      check("chk_len", q_pix.size(), 32'd12);
      for (int i = 0; i < 12 && i < q_pix.size(); i++)
         check($sformatf("chk_pix%0d", i), {24'd0, q_pix[i]},
               {24'd0, exp_chk[i]});

      // LFSR, seed 0 -> 01, two frames back to back
      clear_q();
      pattern = 2'd3;
      seed    = 8'h00;
      cont    = 1'b1;
      pulse_start();
      wait_q(13, 100);
      cont = 1'b0;
      wait_idle(100);
      check("lfsr_len", q_pix.size(), 32'd24);
      for (int i = 0; i < 5 && i < q_pix.size(); i++)
         check($sformatf("lfsr_pix%0d", i), {24'd0, q_pix[i]},
               {24'd0, exp_lfsr[i]});
      if (q_pix.size() >= 13) begin
         check("lfsr_f2_pix", {24'd0, q_pix[12]}, 32'h01);
         check("lfsr_f2_sof", {29'd0, q_flg[12]}, 32'b100);
         check("lfsr_f2_gap", q_cyc[12] - q_cyc[11] - 1, 32'd2);
      end

      // Continuous then stop in frame 3, from a fresh reset
      #1 rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      clear_q();
      pattern = 2'd0;
      cont    = 1'b1;
      pulse_start();
      wait_q(29, 200);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(100);
      stop = 1'b0;
      cont = 1'b0;
      check("cs_len", q_pix.size(), 32'd36);
      check("cs_fcnt", {16'd0, frame_cnt}, 32'd3);
      if (q_pix.size() >= 36) begin
         check("cs_f2_gap", q_cyc[12] - q_cyc[11] - 1, 32'd2);
         check("cs_f3_sof", {29'd0, q_flg[24]}, 32'b100);
         check("cs_f3_p9", {24'd0, q_pix[33]}, 32'd9);
         check("cs_last", {24'd0, q_pix[35]}, 32'd11);
      end

      // Async reset at pixel 6
      clear_q();
      pulse_start();
      for (int k = 0; k < 50 && !(valid_out && pixel_out == 8'd6); k++)
         tick();
      check("ar_reach", {24'd0, pixel_out}, 32'd6);
      #1 rst = 1'b1;
      #1;
      check("ar_valid", {31'd0, valid_out}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_fcnt", {16'd0, frame_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      clear_q();
      pulse_start();
      check("ar_pix0", {24'd0, pixel_out}, 32'd0);
      check("ar_sof", {31'd0, sof}, 32'd1);
      wait_idle(100);
      check("ar_len", q_pix.size(), 32'd12);
      check("ar_fcnt2", {16'd0, frame_cnt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
